// File: rtl/subneg_pkg.sv
// Shared types and constants for the SUBNEG controller and datapath.
// The address-select codes are reused by the datapath memory mux.
package subneg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        F0,
        F1,
        F2,
        R0,
        R1,
        EX,
        WB,
        HALTED
    } state_t;

    localparam logic [1:0] ADDR_PC = 2'd0;
    localparam logic [1:0] ADDR_A  = 2'd1;
    localparam logic [1:0] ADDR_B  = 2'd2;

endpackage

// File: rtl/subneg_ctrl_if.sv
// Control/status bundle between the SUBNEG controller (master) and the datapath/top level (slave).
interface subneg_ctrl_if #(
    parameter int AW = 8,
    parameter int CW = 16
);
    logic          start;
    logic          step;
    logic          alu_neg;
    logic [AW-1:0] c_field;
    logic [1:0]    addr_sel;
    logic          mem_re;
    logic          mem_we;
    logic          pc_inc;
    logic          pc_ld;
    logic          ld_a;
    logic          ld_b;
    logic          ld_c;
    logic          ld_opa;
    logic          ld_opb;
    logic          busy;
    logic          halted;
    logic [CW-1:0] instr_cnt;

    modport master (
        input  start, step, alu_neg, c_field,
        output addr_sel, mem_re, mem_we, pc_inc, pc_ld,
               ld_a, ld_b, ld_c, ld_opa, ld_opb, busy, halted, instr_cnt
    );

    modport slave (
        output start, step, alu_neg, c_field,
        input  addr_sel, mem_re, mem_we, pc_inc, pc_ld,
               ld_a, ld_b, ld_c, ld_opa, ld_opb, busy, halted, instr_cnt
    );
endinterface

// File: rtl/subneg_ctrl.sv
// Sequencer for "subneg A,B,C": three fetches, two operand reads, execute, write-back.
// Strobes are decoded from the registered state; only pc_ld also depends on alu_neg in WB.
module subneg_ctrl
    import subneg_pkg::*;
#(
    parameter int            AW        = 8,
    parameter logic [AW-1:0] HALT_ADDR = 8'hFF,
    parameter int            CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    subneg_ctrl_if.master bus
);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_instr_cnt;

    logic [1:0] w_addr_sel;
    logic       w_mem_re;
    logic       w_mem_we;
    logic       w_pc_inc;
    logic       w_pc_ld;
    logic       w_ld_a;
    logic       w_ld_b;
    logic       w_ld_c;
    logic       w_ld_opa;
    logic       w_ld_opb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == WB) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_addr_sel   = ADDR_PC;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_ld      = 1'b0;
        w_ld_a       = 1'b0;
        w_ld_b       = 1'b0;
        w_ld_c       = 1'b0;
        w_ld_opa     = 1'b0;
        w_ld_opb     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_next_state = F0;
            end
            F0: begin
                w_mem_re     = 1'b1;
                w_pc_inc     = 1'b1;
                w_next_state = F1;
            end
            F1: begin
                w_ld_a       = 1'b1;
                w_mem_re     = 1'b1;
                w_pc_inc     = 1'b1;
                w_next_state = F2;
            end
            F2: begin
                w_ld_b       = 1'b1;
                w_mem_re     = 1'b1;
                w_pc_inc     = 1'b1;
                w_next_state = R0;
            end
            R0: begin
                w_ld_c       = 1'b1;
                w_addr_sel   = ADDR_A;
                w_mem_re     = 1'b1;
                w_next_state = R1;
            end
            R1: begin
                w_ld_opa     = 1'b1;
                w_addr_sel   = ADDR_B;
                w_mem_re     = 1'b1;
                w_next_state = EX;
            end
            EX: begin
                w_ld_opb     = 1'b1;
                w_next_state = WB;
            end
            WB: begin
                w_addr_sel = ADDR_B;
                w_mem_we   = 1'b1;
                w_pc_ld    = bus.alu_neg;
                // A taken branch to HALT_ADDR still completes its write and PC load.
                if (bus.alu_neg && (bus.c_field == HALT_ADDR)) begin
                    w_next_state = HALTED;
                end else if (bus.step) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = F0;
                end
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign bus.addr_sel  = w_addr_sel;
    assign bus.mem_re    = w_mem_re;
    assign bus.mem_we    = w_mem_we;
    assign bus.pc_inc    = w_pc_inc;
    assign bus.pc_ld     = w_pc_ld;
    assign bus.ld_a      = w_ld_a;
    assign bus.ld_b      = w_ld_b;
    assign bus.ld_c      = w_ld_c;
    assign bus.ld_opa    = w_ld_opa;
    assign bus.ld_opb    = w_ld_opb;
    assign bus.busy      = (r_state != IDLE) && (r_state != HALTED);
    assign bus.halted    = (r_state == HALTED);
    assign bus.instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_subneg_ctrl.sv
// Bench for subneg_ctrl: a small datapath with sync RAM executes the program, and an
// instruction-level model (memory copy, PC, retired count) predicts every result.
module tb_subneg_ctrl;
    import subneg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subneg_ctrl_if #(.AW(8), .CW(16)) bus ();
    subneg_ctrl_if #(.AW(8), .CW(2))  bus2 ();

    subneg_ctrl #(.AW(8), .HALT_ADDR(8'hFF), .CW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    subneg_ctrl #(.AW(8), .HALT_ADDR(8'hFF), .CW(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Narrow-counter instance follows the main instance's inputs exactly.
    assign bus2.start   = bus.start;
    assign bus2.step    = bus.step;
    assign bus2.alu_neg = bus.alu_neg;
    assign bus2.c_field = bus.c_field;

    // Datapath: sync RAM, PC, instruction and operand registers.
    logic [7:0] mem [256];
    logic [7:0] rdata, pc, ir_a, ir_b, ir_c, opa, opb;
    logic       ld_en;
    logic [7:0] ld_addr, ld_data;
    logic [7:0] w_addr;
    logic [7:0] w_res;

    always_comb begin
        w_addr = pc;
        case (bus.addr_sel)
            ADDR_A:  w_addr = ir_a;
            ADDR_B:  w_addr = ir_b;
            default: w_addr = pc;
        endcase
    end
    assign w_res       = opb - opa;
    assign bus.alu_neg = w_res[7];
    assign bus.c_field = ir_c;

    always @(posedge clk) begin
        if (rst) pc <= 8'd0;
        else if (bus.pc_ld) pc <= ir_c;
        else if (bus.pc_inc) pc <= pc + 8'd1;
        if (bus.mem_re) rdata <= mem[w_addr];
        if (bus.mem_we) mem[w_addr] <= w_res;
        else if (ld_en) mem[ld_addr] <= ld_data;
        if (bus.ld_a)   ir_a <= rdata;
        if (bus.ld_b)   ir_b <= rdata;
        if (bus.ld_c)   ir_c <= rdata;
        if (bus.ld_opa) opa  <= rdata;
        if (bus.ld_opb) opb  <= rdata;
    end

    // Reference model state.
    logic [7:0] mm [256];
    int mpc;
    int mcnt;
    int n_checks = 0;
    int n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {addr_sel, mem_re, mem_we, pc_inc, pc_ld, ld_a, ld_b, ld_c, ld_opa, ld_opb, busy, halted}
    function automatic logic [12:0] obs_vec();
        return {bus.addr_sel, bus.mem_re, bus.mem_we, bus.pc_inc, bus.pc_ld,
                bus.ld_a, bus.ld_b, bus.ld_c, bus.ld_opa, bus.ld_opb, bus.busy, bus.halted};
    endfunction

    // Expected outputs for cycle k (0..6) of an instruction.
    function automatic logic [12:0] exp_vec(input int k, input logic neg);
        case (k)
            0: return {2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b0};
            1: return {2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10000, 1'b1, 1'b0};
            2: return {2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b01000, 1'b1, 1'b0};
            3: return {2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b0};
            4: return {2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, 1'b1, 1'b0};
            5: return {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00001, 1'b1, 1'b0};
            6: return {2'd2, 1'b0, 1'b1, 1'b0, neg,  5'b00000, 1'b1, 1'b0};
            default: return 13'd0;
        endcase
    endfunction

    localparam logic [12:0] VEC_IDLE   = 13'd0;
    localparam logic [12:0] VEC_HALTED = 13'd1;

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        mm[a]   = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
        mpc  = 0;
        mcnt = 0;
        chk("reset_outputs", obs_vec(), VEC_IDLE);
        chk("reset_cnt", bus.instr_cnt, 0);
    endtask

    // Executes one instruction; with need_start=0 the machine must already be in F0.
    task automatic do_instr(input logic step_v, input logic need_start);
        logic [7:0] ea, eb, ec, res;
        logic       neg, halt;
        ea   = mm[mpc[7:0]];
        eb   = mm[8'(mpc + 1)];
        ec   = mm[8'(mpc + 2)];
        res  = mm[eb] - mm[ea];
        neg  = res[7];
        halt = neg && (ec == 8'hFF);
        if (need_start) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("strobes_k%0d", k), obs_vec(), exp_vec(k, neg));
            bus.start = 1'($urandom_range(0, 1));
            bus.step  = (k == 6) ? step_v : 1'($urandom_range(0, 1));
            tick();
        end
        bus.start = 1'b0;
        mm[eb] = res;
        mpc    = neg ? int'(ec) : ((mpc + 3) & 255);
        mcnt++;
        chk("instr_cnt", bus.instr_cnt, mcnt & 16'hFFFF);
        chk("instr_cnt_cw2", bus2.instr_cnt, mcnt % 4);
        chk("mem_b", mem[eb], res);
        chk("pc", pc, mpc);
        if (halt)        chk("post_halted", obs_vec(), VEC_HALTED);
        else if (step_v) chk("post_idle", obs_vec(), VEC_IDLE);
        else             chk("post_run_f0", obs_vec(), exp_vec(0, 1'b0));
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.step  = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = 8'd0;
        ld_data   = 8'd0;
        tick();

        // Non-negative result: sequential PC.
        do_reset();
        load(8'd0, 8'd3); load(8'd1, 8'd4); load(8'd2, 8'd0);
        load(8'd3, 8'd5); load(8'd4, 8'd10);
        do_instr(1'b1, 1'b1);
        chk("dir1_m4", mem[4], 8'd5);
        chk("dir1_pc", pc, 8'd3);

        // Negative result: branch to C.
        do_reset();
        load(8'd2, 8'd9); load(8'd3, 8'd10); load(8'd4, 8'd5);
        do_instr(1'b1, 1'b1);
        chk("dir2_m4", mem[4], 8'hFB);
        chk("dir2_pc", pc, 8'd9);

        // Reset while in R1 must abort before any write.
        do_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("abort_in_r1", obs_vec(), exp_vec(4, 1'b0));
        rst = 1'b1;
        tick();
        chk("abort_outputs", obs_vec(), VEC_IDLE);
        chk("abort_cnt", bus.instr_cnt, 0);
        chk("abort_mem_b", mem[4], mm[4]);
        rst = 1'b0;
        mpc = 0;
        mcnt = 0;
        tick();
        chk("abort_still_idle", obs_vec(), VEC_IDLE);

        // Random program: code in 0..191, data in 192..255, no halt targets.
        for (int i = 0; i < 192; i += 3) begin
            load(8'(i),     8'($urandom_range(192, 255)));
            load(8'(i + 1), 8'($urandom_range(192, 255)));
            load(8'(i + 2), 8'(3 * $urandom_range(0, 20)));
        end
        for (int i = 192; i < 256; i++) load(8'(i), 8'($urandom));
        do_reset();
        for (int n = 0; n < 10; n++) do_instr(1'b1, 1'b1);
        for (int n = 0; n < 20; n++) do_instr((n == 19) ? 1'b1 : 1'b0, (n == 0) ? 1'b1 : 1'b0);

        // Taken branch to the halt address halts even in run mode.
        do_reset();
        load(8'd0, 8'd200); load(8'd1, 8'd201); load(8'd2, 8'hFF);
        load(8'd200, 8'd7); load(8'd201, 8'd3);
        do_instr(1'b0, 1'b1);
        chk("halt_m201", mem[201], 8'hFC);
        chk("halt_pc", pc, 8'hFF);
        for (int n = 0; n < 3; n++) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            tick();
            chk("halt_sticky", obs_vec(), VEC_HALTED);
            chk("halt_cnt", bus.instr_cnt, 1);
        end
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
